kf_dma_address_count_bank: RTL and testbench

//  Parametrised DMA address/word-count register bank; successor to the fixed 4-ch, 16-bit 8237 block.

---
 rtl/kf_dma_address_count_bank_if.sv | 48 ++++
 rtl/kf_dma_address_count_bank.sv | 200 ++++++++++++++++++++
 tb/tb_kf_dma_address_count_bank.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf_dma_address_count_bank_if.sv
// Bus bundle between the DMA timing/CPU side (master) and the address/count register bank (slave).
interface kf_dma_address_count_bank_if #(
  parameter int CHANNELS    = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) ();
  localparam int NBYTES = ((ADDR_WIDTH > COUNT_WIDTH) ? ADDR_WIDTH : COUNT_WIDTH) / 8;
  localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Every input is a level sampled on each system clock; cpu_clock_negedge is a one-clock strobe
  // that qualifies next_word and transfer_address capture. Pulses out last exactly one clock.
  logic                   cpu_clock_negedge;
  logic [7:0]             data_in;
  logic [7:0]             data_out;
  logic [CHANNELS-1:0]    write_address;
  logic [CHANNELS-1:0]    write_count;
  logic [CHANNELS-1:0]    read_address;
  logic [CHANNELS-1:0]    read_count;
  logic                   clear_byte_pointer;
  logic                   master_clear;
  logic [CHANNELS-1:0]    channel_select;
  logic                   initialize;
  logic [CHANNELS-1:0]    auto_init_config;
  logic                   address_hold_config;
  logic                   decrement_config;
  logic                   next_word;
  logic [PW-1:0]          byte_pointer;
  logic                   terminal_count;
  logic                   update_high_address;
  logic                   address_carry;
  logic [ADDR_WIDTH-1:0]  transfer_address;

  modport master (
    output cpu_clock_negedge, data_in, write_address, write_count, read_address, read_count,
           clear_byte_pointer, master_clear, channel_select, initialize, auto_init_config,
           address_hold_config, decrement_config, next_word,
    input  data_out, byte_pointer, terminal_count, update_high_address, address_carry,
           transfer_address
  );

  modport slave (
    input  cpu_clock_negedge, data_in, write_address, write_count, read_address, read_count,
           clear_byte_pointer, master_clear, channel_select, initialize, auto_init_config,
           address_hold_config, decrement_config, next_word,
    output data_out, byte_pointer, terminal_count, update_high_address, address_carry,
           transfer_address
  );
endinterface

// File: rtl/kf_dma_address_count_bank.sv
// Per-channel DMA base/current address and word-count registers with byte-serial CPU access,
// per-word stepping, autoinitialize on terminal count, and carry/terminal-count pulses.
module kf_dma_address_count_bank #(
  parameter int CHANNELS    = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  kf_dma_address_count_bank_if.slave    io_bank
);
  localparam int NBYTES = ((ADDR_WIDTH > COUNT_WIDTH) ? ADDR_WIDTH : COUNT_WIDTH) / 8;
  localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [ADDR_WIDTH-1:0]   r_base_addr  [CHANNELS];
  logic [ADDR_WIDTH-1:0]   r_cur_addr   [CHANNELS];
  logic [COUNT_WIDTH-1:0]  r_base_count [CHANNELS];
  logic [COUNT_WIDTH-1:0]  r_cur_count  [CHANNELS];
  logic [PW-1:0]           r_byte_ptr;
  logic [2*CHANNELS-1:0]   r_prev_read;
  logic                    r_tc;
  logic                    r_carry;
  logic [ADDR_WIDTH-1:0]   r_xfer_addr;

  logic [SW-1:0]           w_sel_idx;
  logic                    w_sel_valid;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [COUNT_WIDTH-1:0]  w_sel_count;
  logic                    w_sel_wr;
  logic [ADDR_WIDTH-1:0]   w_step_addr;
  logic                    w_underflow;
  logic                    w_wrap;
  logic                    w_do_step;
  logic [2*CHANNELS-1:0]   w_read_vec;
  logic                    w_read_end;
  logic                    w_wr_any;
  logic                    w_rd_hit;
  logic [7:0]              w_read_byte;

  function automatic logic [ADDR_WIDTH-1:0] put_addr_byte(input logic [ADDR_WIDTH-1:0] v,
                                                          input logic [PW-1:0] k, input logic [7:0] d);
    put_addr_byte = v;
    for (int b = 0; b < ADDR_WIDTH/8; b++)
      if (k == PW'(b)) put_addr_byte[b*8 +: 8] = d;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] put_count_byte(input logic [COUNT_WIDTH-1:0] v,
                                                            input logic [PW-1:0] k, input logic [7:0] d);
    put_count_byte = v;
    for (int b = 0; b < COUNT_WIDTH/8; b++)
      if (k == PW'(b)) put_count_byte[b*8 +: 8] = d;
  endfunction

  function automatic logic [7:0] get_addr_byte(input logic [ADDR_WIDTH-1:0] v, input logic [PW-1:0] k);
    get_addr_byte = 8'h00;
    for (int b = 0; b < ADDR_WIDTH/8; b++)
      if (k == PW'(b)) get_addr_byte = v[b*8 +: 8];
  endfunction

  function automatic logic [7:0] get_count_byte(input logic [COUNT_WIDTH-1:0] v, input logic [PW-1:0] k);
    get_count_byte = 8'h00;
    for (int b = 0; b < COUNT_WIDTH/8; b++)
      if (k == PW'(b)) get_count_byte = v[b*8 +: 8];
  endfunction

  // Lowest selected channel wins; an empty select falls back to channel 0 for transfer_address.
  always_comb begin
    w_sel_idx   = '0;
    w_sel_valid = 1'b0;
    for (int c = CHANNELS-1; c >= 0; c--) begin
      if (io_bank.channel_select[c]) begin
        w_sel_idx   = SW'(c);
        w_sel_valid = 1'b1;
      end
    end
  end

  assign w_sel_addr  = r_cur_addr[w_sel_idx];
  assign w_sel_count = r_cur_count[w_sel_idx];
  assign w_sel_wr    = io_bank.write_address[w_sel_idx] | io_bank.write_count[w_sel_idx];
  assign w_underflow = (w_sel_count == '0);
  assign w_do_step   = io_bank.next_word & io_bank.cpu_clock_negedge & w_sel_valid &
                       ~w_sel_wr & ~io_bank.initialize;

  always_comb begin
    w_step_addr = w_sel_addr;
    w_wrap      = 1'b0;
    if (!io_bank.address_hold_config) begin
      if (io_bank.decrement_config) begin
        w_step_addr = w_sel_addr - ADDR_WIDTH'(1);
        w_wrap      = (w_sel_addr == '0);
      end else begin
        w_step_addr = w_sel_addr + ADDR_WIDTH'(1);
        w_wrap      = (w_sel_addr == '1);
      end
    end
  end

  generate
    if (ADDR_WIDTH > 8) begin : g_uha
      assign io_bank.update_high_address = io_bank.next_word &
        (w_step_addr[ADDR_WIDTH-1:8] != r_xfer_addr[ADDR_WIDTH-1:8]);
    end else begin : g_no_uha
      assign io_bank.update_high_address = 1'b0;
    end
  endgenerate

  // Any address read outranks any count read.
  always_comb begin
    w_read_byte = 8'h00;
    w_rd_hit    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!w_rd_hit && io_bank.read_address[c]) begin
        w_read_byte = get_addr_byte(r_cur_addr[c], r_byte_ptr);
        w_rd_hit    = 1'b1;
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (!w_rd_hit && io_bank.read_count[c]) begin
        w_read_byte = get_count_byte(r_cur_count[c], r_byte_ptr);
        w_rd_hit    = 1'b1;
      end
    end
  end

  assign io_bank.data_out = w_read_byte;
  assign w_read_vec = {io_bank.read_count, io_bank.read_address};
  assign w_read_end = (|r_prev_read) && (r_prev_read != w_read_vec);
  assign w_wr_any   = (|io_bank.write_address) | (|io_bank.write_count);

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_base_addr[ch]  <= '0;
          r_cur_addr[ch]   <= '0;
          r_base_count[ch] <= '0;
          r_cur_count[ch]  <= '0;
        end else if (io_bank.master_clear) begin
          r_base_addr[ch]  <= '0;
          r_cur_addr[ch]   <= '0;
          r_base_count[ch] <= '0;
          r_cur_count[ch]  <= '0;
        end else begin
          if (io_bank.write_address[ch]) begin
            r_base_addr[ch] <= put_addr_byte(r_base_addr[ch], r_byte_ptr, io_bank.data_in);
            r_cur_addr[ch]  <= put_addr_byte(r_cur_addr[ch], r_byte_ptr, io_bank.data_in);
          end else if (io_bank.initialize && w_sel_valid && w_sel_idx == SW'(ch)) begin
            r_cur_addr[ch] <= r_base_addr[ch];
          end else if (w_do_step && w_sel_idx == SW'(ch)) begin
            r_cur_addr[ch] <= (w_underflow && io_bank.auto_init_config[ch]) ? r_base_addr[ch]
                                                                              : w_step_addr;
          end
          if (io_bank.write_count[ch]) begin
            r_base_count[ch] <= put_count_byte(r_base_count[ch], r_byte_ptr, io_bank.data_in);
            r_cur_count[ch]  <= put_count_byte(r_cur_count[ch], r_byte_ptr, io_bank.data_in);
          end else if (io_bank.initialize && w_sel_valid && w_sel_idx == SW'(ch)) begin
            r_cur_count[ch] <= r_base_count[ch];
          end else if (w_do_step && w_sel_idx == SW'(ch)) begin
            r_cur_count[ch] <= (w_underflow && io_bank.auto_init_config[ch]) ? r_base_count[ch]
                                                                              : r_cur_count[ch] - COUNT_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_byte_ptr  <= '0;
      r_prev_read <= '0;
      r_tc        <= 1'b0;
      r_carry     <= 1'b0;
      r_xfer_addr <= '0;
    end else if (io_bank.master_clear) begin
      r_byte_ptr  <= '0;
      r_prev_read <= '0;
      r_tc        <= 1'b0;
      r_carry     <= 1'b0;
      r_xfer_addr <= '0;
    end else begin
      if (io_bank.clear_byte_pointer)
        r_byte_ptr <= '0;
      else if (w_wr_any || w_read_end)
        r_byte_ptr <= (r_byte_ptr == PW'(NBYTES-1)) ? '0 : r_byte_ptr + PW'(1);
      r_prev_read <= w_read_vec;
      r_tc        <= w_do_step & w_underflow;
      r_carry     <= w_do_step & w_wrap;
      // Captures the pre-step address, so it lags the current register by one word.
      if (io_bank.cpu_clock_negedge)
        r_xfer_addr <= w_sel_addr;
    end
  end

  assign io_bank.byte_pointer     = r_byte_ptr;
  assign io_bank.terminal_count   = r_tc;
  assign io_bank.address_carry    = r_carry;
  assign io_bank.transfer_address = r_xfer_addr;
endmodule

// File: tb/tb_kf_dma_address_count_bank.sv
// Bench for the DMA address/count bank: directed scenarios plus random traffic against an
// integer-arithmetic reference model; a second 24-bit-address instance covers wide registers.
module tb_kf_dma_address_count_bank;
  localparam int          CH   = 4;
  localparam int unsigned MASK = 32'h0000_FFFF;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  kf_dma_address_count_bank_if #(.CHANNELS(4), .ADDR_WIDTH(16), .COUNT_WIDTH(16)) bus ();
  kf_dma_address_count_bank_if #(.CHANNELS(4), .ADDR_WIDTH(24), .COUNT_WIDTH(16)) bus24 ();

  kf_dma_address_count_bank #(.CHANNELS(4), .ADDR_WIDTH(16), .COUNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .io_bank(bus)
  );
  kf_dma_address_count_bank #(.CHANNELS(4), .ADDR_WIDTH(24), .COUNT_WIDTH(16)) u_dut24 (
    .clock(clock), .reset(reset), .io_bank(bus24)
  );

  always #5 clock = ~clock;

  // Reference model state (16-bit instance)
  int unsigned m_ba[CH], m_ca[CH], m_bc[CH], m_cc[CH];
  int unsigned m_xfer;
  int          m_ptr;
  logic [7:0]  m_prev;
  bit          m_tc, m_carry;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned get_byte(input int unsigned v, input int k);
    return (v >> (8*k)) & 32'hFF;
  endfunction

  function automatic int unsigned put_byte(input int unsigned v, input int k, input int unsigned d);
    return (v & ~(32'hFF << (8*k))) | (d << (8*k));
  endfunction

  function automatic int sel_channel();
    for (int c = 0; c < CH; c++) if (bus.channel_select[c]) return c;
    return -1;
  endfunction

  function automatic int unsigned stepped(input int unsigned a);
    if (bus.address_hold_config) return a;
    if (bus.decrement_config) return (a + MASK) & MASK;
    return (a + 1) & MASK;
  endfunction

  function automatic logic [7:0] exp_data_out();
    for (int c = 0; c < CH; c++) if (bus.read_address[c]) return 8'(get_byte(m_ca[c], m_ptr));
    for (int c = 0; c < CH; c++) if (bus.read_count[c]) return 8'(get_byte(m_cc[c], m_ptr));
    return 8'h00;
  endfunction

  function automatic logic exp_uha();
    int s;
    s = sel_channel();
    if (s < 0) s = 0;
    return bus.next_word && ((stepped(m_ca[s]) >> 8) != (m_xfer >> 8));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ba[c] = 0; m_ca[c] = 0; m_bc[c] = 0; m_cc[c] = 0;
    end
    m_xfer = 0; m_ptr = 0; m_prev = '0; m_tc = 0; m_carry = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int s, sel;
    bit stepping, under, new_tc, new_carry, adv;
    int unsigned sa;
    if (bus.master_clear) begin
      model_reset();
      return;
    end
    sel = sel_channel();
    s = (sel < 0) ? 0 : sel;
    stepping = bus.next_word && bus.cpu_clock_negedge && (sel >= 0) &&
               !(bus.write_address[s] || bus.write_count[s]) && !bus.initialize;
    under     = (m_cc[s] == 0);
    sa        = stepped(m_ca[s]);
    new_tc    = stepping && under;
    new_carry = stepping && !bus.address_hold_config &&
                (bus.decrement_config ? (m_ca[s] == 0) : (m_ca[s] == MASK));
    if (bus.cpu_clock_negedge) m_xfer = m_ca[s];
    for (int c = 0; c < CH; c++) begin
      if (bus.write_address[c]) begin
        m_ba[c] = put_byte(m_ba[c], m_ptr, bus.data_in);
        m_ca[c] = put_byte(m_ca[c], m_ptr, bus.data_in);
      end else if (bus.initialize && sel == c) m_ca[c] = m_ba[c];
      else if (stepping && c == s) m_ca[c] = (under && bus.auto_init_config[c]) ? m_ba[c] : sa;
      if (bus.write_count[c]) begin
        m_bc[c] = put_byte(m_bc[c], m_ptr, bus.data_in);
        m_cc[c] = put_byte(m_cc[c], m_ptr, bus.data_in);
      end else if (bus.initialize && sel == c) m_cc[c] = m_bc[c];
      else if (stepping && c == s)
        m_cc[c] = (under && bus.auto_init_config[c]) ? m_bc[c] : ((m_cc[c] + MASK) & MASK);
    end
    adv = (bus.write_address != 0) || (bus.write_count != 0) ||
          (m_prev != 0 && m_prev != {bus.read_count, bus.read_address});
    if (bus.clear_byte_pointer) m_ptr = 0;
    else if (adv) m_ptr = (m_ptr + 1) % 2;
    m_prev  = {bus.read_count, bus.read_address};
    m_tc    = new_tc;
    m_carry = new_carry;
  endtask

  task automatic idle();
    bus.cpu_clock_negedge = 0; bus.data_in = '0; bus.write_address = '0; bus.write_count = '0;
    bus.read_address = '0; bus.read_count = '0; bus.clear_byte_pointer = 0; bus.master_clear = 0;
    bus.channel_select = '0; bus.initialize = 0; bus.auto_init_config = '0;
    bus.address_hold_config = 0; bus.decrement_config = 0; bus.next_word = 0;
  endtask

  task automatic idle24();
    bus24.cpu_clock_negedge = 0; bus24.data_in = '0; bus24.write_address = '0; bus24.write_count = '0;
    bus24.read_address = '0; bus24.read_count = '0; bus24.clear_byte_pointer = 0; bus24.master_clear = 0;
    bus24.channel_select = '0; bus24.initialize = 0; bus24.auto_init_config = '0;
    bus24.address_hold_config = 0; bus24.decrement_config = 0; bus24.next_word = 0;
  endtask

  task automatic step_inputs(input logic [3:0] sel);
    bus.channel_select = sel; bus.next_word = 1; bus.cpu_clock_negedge = 1;
  endtask

  // Called at a negedge with inputs applied: compare all outputs, advance model, move to next negedge.
  task automatic run_cycle();
    #1;
    check("data_out", bus.data_out, exp_data_out());
    check("update_high_address", bus.update_high_address, exp_uha());
    check("byte_pointer", bus.byte_pointer, m_ptr);
    check("terminal_count", bus.terminal_count, m_tc);
    check("address_carry", bus.address_carry, m_carry);
    check("transfer_address", bus.transfer_address, m_xfer);
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_random();
    int r;
    idle();
    bus.master_clear       = ($urandom_range(0, 99) == 0);
    bus.clear_byte_pointer = ($urandom_range(0, 15) == 0);
    r = $urandom_range(0, 7);
    if (r == 0) bus.write_address = 4'(1 << $urandom_range(0, 3));
    else if (r == 1) bus.write_count = 4'(1 << $urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: bus.data_in = 8'h00;
      1: bus.data_in = 8'hFF;
      2: bus.data_in = 8'h01;
      default: bus.data_in = 8'($urandom_range(0, 255));
    endcase
    r = $urandom_range(0, 5);
    if (r == 0) bus.read_address = 4'(1 << $urandom_range(0, 3));
    else if (r == 1) bus.read_count = 4'(1 << $urandom_range(0, 3));
    bus.channel_select      = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'(1 << $urandom_range(0, 3));
    bus.initialize          = ($urandom_range(0, 31) == 0);
    bus.auto_init_config    = 4'($urandom_range(0, 15));
    bus.address_hold_config = ($urandom_range(0, 7) == 0);
    bus.decrement_config    = 1'($urandom_range(0, 1));
    bus.next_word           = ($urandom_range(0, 3) != 0);
    bus.cpu_clock_negedge   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t_bytes [3];
    logic [7:0] t_exp   [4];
    reset = 1;
    idle();
    idle24();
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_xfer", bus.transfer_address, 0);
    check("rst_ptr", bus.byte_pointer, 0);
    check("rst_tc", bus.terminal_count, 0);
    check("rst_carry", bus.address_carry, 0);
    check("rst24_xfer", bus24.transfer_address, 0);
    reset = 0;

    // T5: 24-bit address, byte-serial write/read, write beats step
    bus24.clear_byte_pointer = 1; run_cycle(); bus24.clear_byte_pointer = 0;
    t_bytes[0] = 8'h56; t_bytes[1] = 8'h34; t_bytes[2] = 8'h12;
    bus24.write_address = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bus24.data_in = t_bytes[k];
      run_cycle();
      check("t5_ptr", bus24.byte_pointer, (k + 1) % 3);
    end
    bus24.write_address = '0;
    for (int k = 0; k < 3; k++) begin
      bus24.read_address = 4'b0001;
      #1 check("t5_read", bus24.data_out, t_bytes[k]);
      run_cycle();
      bus24.read_address = '0;
      run_cycle();
    end
    bus24.write_address = 4'b0001; bus24.data_in = 8'hAA;
    bus24.channel_select = 4'b0001; bus24.next_word = 1; bus24.cpu_clock_negedge = 1;
    run_cycle();
    idle24();
    check("t5_no_tc", bus24.terminal_count, 0);
    check("t5_xfer", bus24.transfer_address, 32'h123456);
    bus24.clear_byte_pointer = 1; run_cycle(); bus24.clear_byte_pointer = 0;
    bus24.read_address = 4'b0001;
    #1 check("t5_write_kept", bus24.data_out, 8'hAA);
    run_cycle(); idle24(); run_cycle();
    bus24.read_count = 4'b0001;
    #1 check("t5_count_unstepped", bus24.data_out, 8'h00);
    run_cycle(); idle24(); run_cycle();
    bus24.read_count = 4'b0001;
    #1 check("t5_count_beyond_width", bus24.data_out, 8'h00);
    run_cycle(); idle24();

    // T1: ch1 address write/readback
    bus.clear_byte_pointer = 1; run_cycle(); idle();
    bus.write_address = 4'b0010; bus.data_in = 8'h34; run_cycle();
    check("t1_ptr1", bus.byte_pointer, 1);
    bus.data_in = 8'h12; run_cycle();
    check("t1_ptr0", bus.byte_pointer, 0);
    idle();
    bus.read_address = 4'b0010;
    #1 check("t1_rd_lo", bus.data_out, 8'h34);
    run_cycle(); idle(); run_cycle();
    bus.read_address = 4'b0010;
    #1 check("t1_rd_hi", bus.data_out, 8'h12);
    run_cycle(); idle(); run_cycle();
    check("t1_ptr_end", bus.byte_pointer, 0);

    // T2: ch0 count 1 -> 0 -> FFFF, single TC pulse on second step
    bus.clear_byte_pointer = 1; run_cycle(); idle();
    bus.write_count = 4'b0001; bus.data_in = 8'h01; run_cycle();
    bus.data_in = 8'h00; run_cycle(); idle();
    t_exp[0] = 8'h01; t_exp[1] = 8'h00; t_exp[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.read_count = 4'b0001;
      if (i < 2) step_inputs(4'b0001);
      #1 check("t2_count", bus.data_out, t_exp[i]);
      check("t2_tc", bus.terminal_count, (i == 2));
      run_cycle();
    end
    idle();
    #1 check("t2_tc_off", bus.terminal_count, 0);
    run_cycle();

    // T3: ch2 autoinitialize reload on terminal count
    bus.clear_byte_pointer = 1; run_cycle(); idle();
    bus.write_address = 4'b0100; bus.data_in = 8'h00; run_cycle();
    bus.data_in = 8'h01; run_cycle(); idle();
    bus.write_count = 4'b0100; bus.data_in = 8'h02; run_cycle();
    bus.data_in = 8'h00; run_cycle(); idle();
    t_exp[0] = 8'h00; t_exp[1] = 8'h01; t_exp[2] = 8'h02; t_exp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.read_address = 4'b0100; bus.auto_init_config = 4'b0100;
      if (i < 3) step_inputs(4'b0100);
      #1 check("t3_addr_lo", bus.data_out, t_exp[i]);
      check("t3_tc", bus.terminal_count, (i == 3));
      if (i == 3) check("t3_xfer", bus.transfer_address, 32'h0102);
      run_cycle();
    end
    idle(); run_cycle();

    // T4: high-address update at 0x00FF, carry at 0xFFFF
    bus.clear_byte_pointer = 1; run_cycle(); idle();
    bus.write_address = 4'b1000; bus.data_in = 8'hFF; run_cycle();
    bus.data_in = 8'h00; run_cycle(); idle();
    bus.channel_select = 4'b1000; bus.cpu_clock_negedge = 1; run_cycle();
    step_inputs(4'b1000);
    #1 check("t4_uha_pre", bus.update_high_address, 1);
    run_cycle(); idle();
    bus.read_address = 4'b1000;
    #1 check("t4_addr_lo", bus.data_out, 8'h00);
    run_cycle(); idle(); run_cycle();
    bus.read_address = 4'b1000;
    #1 check("t4_addr_hi", bus.data_out, 8'h01);
    run_cycle(); idle(); run_cycle();
    bus.write_address = 4'b1000; bus.data_in = 8'hFF; run_cycle(); run_cycle(); idle();
    step_inputs(4'b1000); run_cycle(); idle();
    #1 check("t4_carry", bus.address_carry, 1);
    run_cycle();
    #1 check("t4_carry_off", bus.address_carry, 0);

    // T6: master_clear during stepping
    step_inputs(4'b1000); run_cycle(); run_cycle();
    bus.master_clear = 1; run_cycle(); idle();
    #1 check("t6_xfer", bus.transfer_address, 0);
    check("t6_ptr", bus.byte_pointer, 0);
    check("t6_tc", bus.terminal_count, 0);
    check("t6_carry", bus.address_carry, 0);
    bus.read_address = 4'b1000;
    #1 check("t6_addr", bus.data_out, 0);
    run_cycle(); idle(); run_cycle();

    // Random traffic with an asynchronous reset injected mid-run
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      if (n == 1500) begin
        #2 reset = 1;
        #1 check("rst_mid_xfer", bus.transfer_address, 0);
        check("rst_mid_ptr", bus.byte_pointer, 0);
        check("rst_mid_tc", bus.terminal_count, 0);
        check("rst_mid_carry", bus.address_carry, 0);
        check("rst_mid_data", bus.data_out, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        drive_random();
      end
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
